// File: rtl/debug_axi_reader_block.sv
// Debug AXI reader: fetches fixed-length AXI4 read bursts into a small beat buffer and
// streams every captured byte out of an 8N1 UART, LSB byte first, until TOTAL_PACKAGE
// beats have been read for one read_start.
module debug_axi_reader_block #(
    parameter int unsigned TOTAL_PACKAGE      = 400,
    parameter int unsigned DATA_DEPTH         = 16,
    parameter int unsigned DATA_BYTE_SHIFT    = 5,
    parameter int unsigned DATA_BYTE_WIDTH    = 32,
    parameter int unsigned CLK_FRE            = 50,
    parameter int unsigned BAUD_RATE          = 115200,
    parameter int unsigned TX_DATA_BYTE_WIDTH = DATA_BYTE_WIDTH,
    parameter int unsigned RX_DATA_BYTE_WIDTH = DATA_BYTE_WIDTH,
    localparam int unsigned DW                = DATA_BYTE_WIDTH * 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          read_start,
    input  logic [31:0]   AXI_reader_axi_araddr_start,
    input  logic          uart_rx,
    output logic          uart_tx,
    output logic [3:0]    AXI_reader_axi_arid,
    output logic [31:0]   AXI_reader_axi_araddr,
    output logic [7:0]    AXI_reader_axi_arlen,
    output logic [2:0]    AXI_reader_axi_arsize,
    output logic [1:0]    AXI_reader_axi_arburst,
    output logic          AXI_reader_axi_arvalid,
    input  logic          AXI_reader_axi_arready,
    input  logic [3:0]    AXI_reader_axi_rid,
    input  logic [DW-1:0] AXI_reader_axi_rdata,
    input  logic [1:0]    AXI_reader_axi_rresp,
    input  logic          AXI_reader_axi_rlast,
    input  logic          AXI_reader_axi_rvalid,
    output logic          AXI_reader_axi_rready
);

    localparam int unsigned BitPeriod = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int unsigned IdxW      = $clog2(DATA_DEPTH + 1);
    localparam int unsigned AddrW     = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam int unsigned ByteW     = (DATA_BYTE_WIDTH > 1) ? $clog2(DATA_BYTE_WIDTH) : 1;

    localparam logic [31:0]      BurstBytes = 32'(DATA_DEPTH) << DATA_BYTE_SHIFT;
    localparam logic [31:0]      LastBaud   = 32'(BitPeriod - 1);
    localparam logic [31:0]      TotalBeats = 32'(TOTAL_PACKAGE);
    localparam logic [IdxW-1:0]  LastIdx    = IdxW'(DATA_DEPTH - 1);
    localparam logic [ByteW-1:0] LastByte   = ByteW'(DATA_BYTE_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAr,
        StR,
        StTx,
        StNext
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             arvalid_q, arvalid_d;
    logic             rready_q, rready_d;
    logic             tx_q, tx_d;
    logic [31:0]      baud_q, baud_d;
    logic [3:0]       bit_q, bit_d;
    logic [IdxW-1:0]  tx_beat_q, tx_beat_d;
    logic [ByteW-1:0] tx_byte_q, tx_byte_d;

    logic [DW-1:0]    beat_mem [DATA_DEPTH];
    logic             beat_we;
    logic [DW-1:0]    cur_beat;
    logic [7:0]       cur_byte;
    logic [31:0]      cnt_sum;

    // Inputs and parameters kept only for interface compatibility.
    logic unused_inputs;
    assign unused_inputs = ^{uart_rx, AXI_reader_axi_rid, AXI_reader_axi_rresp,
                             1'(TX_DATA_BYTE_WIDTH), 1'(RX_DATA_BYTE_WIDTH)};

    assign AXI_reader_axi_arid    = 4'd0;
    assign AXI_reader_axi_arlen   = 8'(DATA_DEPTH - 1);
    assign AXI_reader_axi_arsize  = 3'(DATA_BYTE_SHIFT);
    assign AXI_reader_axi_arburst = 2'b01;
    assign AXI_reader_axi_araddr  = addr_q;
    assign AXI_reader_axi_arvalid = arvalid_q;
    assign AXI_reader_axi_rready  = rready_q;
    assign uart_tx                = tx_q;

    assign beat_we  = (state_q == StR) && AXI_reader_axi_rvalid && rready_q;
    assign cur_beat = beat_mem[tx_beat_q[AddrW-1:0]];
    assign cur_byte = cur_beat[{tx_byte_q, 3'b000} +: 8];
    assign cnt_sum  = cnt_q + 32'(idx_q);

    // Beat buffer: plain storage, contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (beat_we) begin
            beat_mem[idx_q[AddrW-1:0]] <= AXI_reader_axi_rdata;
        end
    end

    // Next-state logic for the burst sequencer and the UART shifter it drives.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        tx_d      = tx_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        tx_beat_d = tx_beat_q;
        tx_byte_d = tx_byte_q;

        unique case (state_q)
            StIdle: begin
                if (read_start) begin
                    addr_d    = AXI_reader_axi_araddr_start;
                    cnt_d     = '0;
                    idx_d     = '0;
                    arvalid_d = 1'b1;
                    state_d   = StAr;
                end
            end
            StAr: begin
                if (AXI_reader_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StR;
                end
            end
            StR: begin
                if (AXI_reader_axi_rvalid) begin
                    idx_d = idx_q + IdxW'(1);
                    // Stop on rlast or once the buffer is full, whichever is first.
                    if (AXI_reader_axi_rlast || (idx_q == LastIdx)) begin
                        rready_d  = 1'b0;
                        tx_beat_d = '0;
                        tx_byte_d = '0;
                        bit_d     = '0;
                        baud_d    = '0;
                        tx_d      = 1'b0;
                        state_d   = StTx;
                    end
                end
            end
            StTx: begin
                if (baud_q != LastBaud) begin
                    baud_d = baud_q + 32'd1;
                end else begin
                    baud_d = '0;
                    if (bit_q != 4'd9) begin
                        // Bits 1..8 carry data LSB first, bit 9 is the stop bit.
                        bit_d = bit_q + 4'd1;
                        tx_d  = (bit_q < 4'd8) ? cur_byte[bit_q[2:0]] : 1'b1;
                    end else if ((tx_byte_q == LastByte) && (tx_beat_q == idx_q - IdxW'(1))) begin
                        state_d = StNext;
                    end else begin
                        bit_d = '0;
                        tx_d  = 1'b0;
                        if (tx_byte_q == LastByte) begin
                            tx_byte_d = '0;
                            tx_beat_d = tx_beat_q + IdxW'(1);
                        end else begin
                            tx_byte_d = tx_byte_q + ByteW'(1);
                        end
                    end
                end
            end
            StNext: begin
                cnt_d  = cnt_sum;
                addr_d = addr_q + BurstBytes;
                idx_d  = '0;
                if (cnt_sum >= TotalBeats) begin
                    state_d = StIdle;
                end else begin
                    arvalid_d = 1'b1;
                    state_d   = StAr;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // All sequencer state and registered outputs; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            tx_q      <= 1'b1;
            baud_q    <= '0;
            bit_q     <= '0;
            tx_beat_q <= '0;
            tx_byte_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            tx_q      <= tx_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            tx_beat_q <= tx_beat_d;
            tx_byte_q <= tx_byte_d;
        end
    end

endmodule

// File: tb/tb_debug_axi_reader_block.sv
// Bench for debug_axi_reader_block: a randomized AXI read slave plus a UART frame decoder,
// checked against burst/byte expectations computed from a per-run burst plan.
module tb_debug_axi_reader_block;

    localparam int unsigned TotalPkg    = 6;
    localparam int unsigned Depth       = 4;
    localparam int unsigned Shift       = 2;
    localparam int unsigned ByteWidth   = 4;
    localparam int unsigned ClkFre      = 1;
    localparam int unsigned Baud        = 250000;
    localparam int unsigned Dw          = ByteWidth * 8;
    localparam int unsigned BitCycles   = ClkFre * 1000000 / Baud;
    localparam int unsigned FrameCycles = 10 * BitCycles;
    localparam int unsigned BurstBytes  = Depth << Shift;
    localparam int unsigned ClkPeriod   = 10;

    logic          clk;
    logic          rst_n;
    logic          read_start;
    logic [31:0]   araddr_start;
    logic          uart_rx;
    logic          uart_tx;
    logic [3:0]    arid;
    logic [31:0]   araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready;
    logic [3:0]    rid;
    logic [Dw-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;

    debug_axi_reader_block #(
        .TOTAL_PACKAGE  (TotalPkg),
        .DATA_DEPTH     (Depth),
        .DATA_BYTE_SHIFT(Shift),
        .DATA_BYTE_WIDTH(ByteWidth),
        .CLK_FRE        (ClkFre),
        .BAUD_RATE      (Baud)
    ) u_dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .read_start                 (read_start),
        .AXI_reader_axi_araddr_start(araddr_start),
        .uart_rx                    (uart_rx),
        .uart_tx                    (uart_tx),
        .AXI_reader_axi_arid        (arid),
        .AXI_reader_axi_araddr      (araddr),
        .AXI_reader_axi_arlen       (arlen),
        .AXI_reader_axi_arsize      (arsize),
        .AXI_reader_axi_arburst     (arburst),
        .AXI_reader_axi_arvalid     (arvalid),
        .AXI_reader_axi_arready     (arready),
        .AXI_reader_axi_rid         (rid),
        .AXI_reader_axi_rdata       (rdata),
        .AXI_reader_axi_rresp       (rresp),
        .AXI_reader_axi_rlast       (rlast),
        .AXI_reader_axi_rvalid      (rvalid),
        .AXI_reader_axi_rready      (rready)
    );

    initial clk = 1'b0;
    always #(ClkPeriod / 2) clk = ~clk;

    int unsigned n_vec;
    int unsigned n_err;
    int unsigned epoch;
    bit          directed;

    // Burst plan consumed by the slave, and expectations derived from it.
    int unsigned   plan_len[$];
    bit            plan_full_last[$];
    int unsigned   plan_delay[$];
    logic [Dw-1:0] plan_data[$];
    logic [31:0]   exp_addr[$];
    logic [31:0]   got_addr[$];
    logic [7:0]    exp_bytes[$];
    bit            exp_first[$];
    logic [7:0]    rx_bytes[$];
    time           rx_time[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // AXI read slave: random arready delay, random rvalid gaps, optional early rlast.
    initial begin : slave
        int unsigned len;
        int unsigned dly;
        int unsigned gap;
        int unsigned guard;
        bit          full_last;
        logic [31:0] a0;
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        rdata   = '0;
        rid     = '0;
        rresp   = '0;
        forever begin
            do @(negedge clk); while (!(rst_n && arvalid));
            a0        = araddr;
            len       = (plan_len.size() > 0) ? plan_len.pop_front() : Depth;
            full_last = (plan_full_last.size() > 0) ? plan_full_last.pop_front() : 1'b1;
            dly       = (plan_delay.size() > 0) ? plan_delay.pop_front() : 0;
            for (int i = 0; i < dly; i++) begin
                @(negedge clk);
                check_eq("ar_hold", {arvalid, araddr}, {1'b1, a0});
            end
            arready = 1'b1;
            got_addr.push_back(araddr);
            @(negedge clk);
            arready = 1'b0;
            check_eq("ar_single", arvalid, 1'b0);
            for (int k = 0; k < len; k++) begin
                gap = directed ? 0 : $urandom_range(0, 2);
                repeat (gap) @(negedge clk);
                rvalid = 1'b1;
                rdata  = (plan_data.size() > 0) ? plan_data.pop_front() : '0;
                rlast  = (k == int'(len) - 1) && ((len < Depth) || full_last);
                rid    = 4'($urandom);
                rresp  = 2'($urandom);
                guard  = 0;
                while (!rready && guard < 50) begin
                    @(negedge clk);
                    guard++;
                end
                if (!rready) check_eq("rready_wait", rready, 1'b1);
                @(negedge clk);
                rvalid = 1'b0;
                rlast  = 1'b0;
            end
        end
    end

    // UART decoder: samples every cycle of a frame, decodes mid-bit, timestamps the start edge.
    initial begin : uart_mon
        logic [FrameCycles-1:0] bits;
        logic [7:0]             b;
        int unsigned            ep;
        time                    t0;
        bit                     ok;
        forever begin
            @(negedge clk);
            if (rst_n && uart_tx == 1'b0) begin
                ep = epoch;
                t0 = $time;
                for (int j = 0; j < int'(FrameCycles); j++) begin
                    if (j > 0) @(negedge clk);
                    bits[j] = uart_tx;
                end
                if (ep == epoch) begin
                    ok = 1'b1;
                    for (int k = 0; k < 10; k++) begin
                        for (int s = 0; s < int'(BitCycles); s++) begin
                            if (bits[k * BitCycles + s] != bits[k * BitCycles]) ok = 1'b0;
                        end
                    end
                    if (bits[0] != 1'b0 || bits[9 * BitCycles] != 1'b1) ok = 1'b0;
                    check_eq("frame_shape", ok, 1'b1);
                    for (int d = 0; d < 8; d++) b[d] = bits[(d + 1) * BitCycles + BitCycles / 2];
                    rx_bytes.push_back(b);
                    rx_time.push_back(t0);
                end
            end
        end
    end

    task automatic wait_bytes(input int unsigned n, input int unsigned limit);
        int unsigned g;
        g = 0;
        while (rx_bytes.size() < n && g < limit) begin
            @(negedge clk);
            g++;
        end
        if (rx_bytes.size() < n) check_eq("byte_timeout", rx_bytes.size(), n);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_arvalid"}, arvalid, 1'b0);
        check_eq({tag, "_rready"}, rready, 1'b0);
        check_eq({tag, "_uart_tx"}, uart_tx, 1'b1);
    endtask

    // One read_start: build a burst plan, run it, compare addresses, bytes and frame timing.
    task automatic run_seq(input logic [31:0] start, input bit dir, input bit restart,
                           input bit rst_mid);
        int unsigned   total;
        int unsigned   nb;
        int unsigned   len;
        int unsigned   viol;
        int unsigned   n;
        logic [Dw-1:0] beat;
        plan_len.delete();
        plan_full_last.delete();
        plan_delay.delete();
        plan_data.delete();
        exp_addr.delete();
        got_addr.delete();
        exp_bytes.delete();
        exp_first.delete();
        rx_bytes.delete();
        rx_time.delete();
        directed = dir;
        total = 0;
        nb    = 0;
        while (total < TotalPkg) begin
            len = (dir || $urandom_range(0, 1) == 1) ? Depth : $urandom_range(1, Depth);
            plan_len.push_back(len);
            plan_full_last.push_back(dir ? 1'b1 : 1'($urandom));
            plan_delay.push_back(dir ? 0 : $urandom_range(0, 5));
            exp_addr.push_back(start + nb * BurstBytes);
            for (int k = 0; k < int'(len); k++) begin
                beat = dir ? {ByteWidth{8'(total + k)}} : Dw'($urandom);
                plan_data.push_back(beat);
                for (int i = 0; i < int'(ByteWidth); i++) begin
                    exp_bytes.push_back(beat[8 * i +: 8]);
                    exp_first.push_back(k == 0 && i == 0);
                end
            end
            total += len;
            nb++;
        end

        @(negedge clk);
        araddr_start = start;
        read_start   = 1'b1;
        @(negedge clk);
        read_start   = 1'b0;
        araddr_start = $urandom;

        if (restart) begin
            wait_bytes(1, 4000);
            araddr_start = $urandom;
            read_start   = 1'b1;
            @(negedge clk);
            read_start   = 1'b0;
        end

        if (rst_mid) begin
            wait_bytes(2, 4000);
            #2;
            rst_n = 1'b0;
            epoch++;
            #1;
            check_idle_outputs("rst_async");
            check_eq("rst_araddr", araddr, 32'h0);
            @(negedge clk);
            rst_n = 1'b1;
            viol  = 0;
            repeat (100) begin
                @(negedge clk);
                if (!uart_tx || arvalid || rready) viol++;
            end
            check_eq("post_reset_quiet", viol, 0);
            check_eq("post_reset_bytes", rx_bytes.size(), 2);
            for (int i = 0; i < 2 && i < rx_bytes.size(); i++) begin
                check_eq("pre_reset_byte", rx_bytes[i], exp_bytes[i]);
            end
            check_eq("pre_reset_ar_count", got_addr.size(), 1);
            if (got_addr.size() > 0) check_eq("pre_reset_addr", got_addr[0], exp_addr[0]);
        end else begin
            wait_bytes(exp_bytes.size(), 8000);
            repeat (60) @(negedge clk);
            check_idle_outputs("done");
            check_eq("ar_count", got_addr.size(), exp_addr.size());
            n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
            for (int i = 0; i < int'(n); i++) check_eq("ar_addr", got_addr[i], exp_addr[i]);
            check_eq("byte_count", rx_bytes.size(), exp_bytes.size());
            n = (rx_bytes.size() < exp_bytes.size()) ? rx_bytes.size() : exp_bytes.size();
            for (int i = 0; i < int'(n); i++) begin
                check_eq("uart_byte", rx_bytes[i], exp_bytes[i]);
                if (i > 0 && !exp_first[i]) begin
                    check_eq("frame_gap", rx_time[i] - rx_time[i - 1], FrameCycles * ClkPeriod);
                end
            end
        end
    endtask

    initial begin : watchdog
        #(ClkPeriod * 50000);
        $display("FAIL watchdog: simulation did not complete within the cycle budget");
        $fatal(1);
    end

    initial begin : main
        n_vec        = 0;
        n_err        = 0;
        epoch        = 0;
        directed     = 1'b0;
        rst_n        = 1'b1;
        read_start   = 1'b0;
        araddr_start = '0;
        uart_rx      = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("reset");
        check_eq("reset_araddr", araddr, 32'h0);
        check_eq("arid", arid, 4'd0);
        check_eq("arlen", arlen, Depth - 1);
        check_eq("arsize", arsize, Shift);
        check_eq("arburst", arburst, 2'b01);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("idle");

        run_seq(32'h0000_0000, 1'b1, 1'b0, 1'b0);
        run_seq($urandom, 1'b0, 1'b0, 1'b0);
        run_seq($urandom, 1'b0, 1'b0, 1'b0);
        run_seq(32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0);
        run_seq($urandom, 1'b0, 1'b1, 1'b0);
        run_seq($urandom, 1'b0, 1'b0, 1'b1);
        run_seq(32'h0000_0100, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/debug_axi_reader_block.md
DEBUG_AXI_READER_BLOCK -- requirements
Module: debug_axi_reader

Interface
REQ-001 SHALL have parameter TOTAL_PACKAGE, default 400, total 256-bit beats read per start.
REQ-002 SHALL have parameter DATA_DEPTH, default 16, beats per AXI burst and buffer depth.
REQ-003 SHALL have parameter DATA_BYTE_SHIFT, default 5, log2 of bytes per beat.
REQ-004 SHALL have parameter DATA_BYTE_WIDTH, default 32, bytes per beat; data width DW = DATA_BYTE_WIDTH*8.
REQ-005 SHALL have parameters CLK_FRE (MHz), default 50, and BAUD_RATE, default 115200.
REQ-006 SHALL have parameters TX_DATA_BYTE_WIDTH and RX_DATA_BYTE_WIDTH, both defaulting to DATA_BYTE_WIDTH; declared for interface compatibility, no effect on behaviour.
REQ-007 SHALL use one clock and an asynchronous, active-low reset: clk in 1, rising-edge system clock; rst_n in 1, async active-low reset.
REQ-008 read_start in 1: single-cycle start pulse. AXI_reader_axi_araddr_start in 32: first burst address.
REQ-009 uart_rx in 1: unused. uart_tx out 1: UART 8N1 serial output.
REQ-010 AXI_reader_axi_arid out 4; AXI_reader_axi_araddr out 32; AXI_reader_axi_arlen out 8; AXI_reader_axi_arsize out 3; AXI_reader_axi_arburst out 2; AXI_reader_axi_arvalid out 1; AXI_reader_axi_arready in 1.
REQ-011 AXI_reader_axi_rid in 4; AXI_reader_axi_rdata in DW; AXI_reader_axi_rresp in 2; AXI_reader_axi_rlast in 1; AXI_reader_axi_rvalid in 1; AXI_reader_axi_rready out 1.

Function
REQ-012 SHALL drive arid=0, arlen=DATA_DEPTH-1, arsize=DATA_BYTE_SHIFT, arburst=2'b01 (INCR) as constants.
REQ-013 SHALL implement FSM IDLE -> AR -> R -> TX -> NEXT -> (AR or IDLE).
REQ-014 IDLE: read_start=1 latches araddr_start into the address register, clears the beat counter, moves to AR; read_start is ignored in all other states.
REQ-015 AR: arvalid=1, araddr=address register; held stable until the arvalid&&arready cycle, then to R with arvalid=0 on the next cycle.
REQ-016 R: rready=1; each rvalid&&rready beat writes rdata to buffer[index], index incrementing from 0; on the beat with rlast=1, or the DATA_DEPTH-th beat, whichever comes first, rready drops and state goes to TX.
REQ-017 rid and rresp are ignored; beats are stored regardless of response code.
REQ-018 TX: transmits buffer beats 0..N-1 (N = beats captured), each beat as DATA_BYTE_WIDTH bytes, least-significant byte (rdata[7:0]) first, next byte only after the previous stop bit completes.
REQ-019 NEXT: beat counter += N; address += DATA_DEPTH<<DATA_BYTE_SHIFT (512 by default); counter >= TOTAL_PACKAGE -> IDLE, else AR.
REQ-020 Final burst is not truncated: TOTAL_PACKAGE not a multiple of DATA_DEPTH still issues full bursts; all captured beats are transmitted.
REQ-021 UART: bit period = CLK_FRE*1000000/BAUD_RATE cycles (434 by default), frame = start 0, 8 data LSB first, stop 1; line idles at 1; frames back-to-back with no extra gap.
REQ-022 Address arithmetic 32-bit and wraps modulo 2^32.

Reset
REQ-023 rst_n=0 asynchronously forces IDLE: arvalid=0, rready=0, araddr=0, uart_tx=1, counters and buffer index 0, UART bit counter idle; buffer contents need not be cleared.
REQ-024 Reset mid-burst or mid-frame aborts the operation; no resumption after release; a new read_start is required.

Verification
REQ-025 Start at addr 0, slave arready=1, rdata of beat k = k replicated per byte -> AR at addr 0, 512, ..., 12288 (25 bursts), arlen=15, arsize=5, arburst=1; 12800 bytes on uart_tx.
REQ-026 Slave delays arready 5 cycles -> araddr/arvalid stable throughout; exactly one handshake per burst.
REQ-027 rvalid gapped every other cycle -> all 16 beats captured in order; first UART byte equals beat0 rdata[7:0], frame bit width 434 cycles.
REQ-028 read_start pulsed again during TX -> ignored; address sequence and byte count unchanged.
REQ-029 rst_n asserted mid-TX -> uart_tx=1 and arvalid=0 immediately; no activity until next read_start.
REQ-030 TOTAL_PACKAGE=20, DATA_DEPTH=16 -> two bursts (addr 0, 512), 32 beats / 1024 bytes transmitted, then IDLE.
